// File: rtl/io_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_timer_pkg
//  Description : Register map, clock-select codes and helpers for io_timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package io_timer_pkg;

   localparam logic [1:0] c_reg_tccr  = 2'd0;
   localparam logic [1:0] c_reg_tcnt  = 2'd1;
   localparam logic [1:0] c_reg_ocr   = 2'd2;
   localparam logic [1:0] c_reg_tifr  = 2'd3;
   localparam int         c_reg_count = 4;

   localparam int c_tccr_ctc  = 3;
   localparam int c_tccr_toie = 4;
   localparam int c_tccr_ocie = 5;
   localparam int c_tifr_tov  = 0;
   localparam int c_tifr_ocf  = 1;

   typedef enum logic [2:0] {
      CS_STOP    = 3'd0,
      CS_DIV1    = 3'd1,
      CS_DIV8    = 3'd2,
      CS_DIV64   = 3'd3,
      CS_DIV256  = 3'd4,
      CS_DIV1024 = 3'd5,
      CS_RSVD6   = 3'd6,
      CS_RSVD7   = 3'd7
   } cs_e;

   typedef struct packed {
      logic ocie;
      logic toie;
      logic ctc;
      cs_e  cs;
   } tccr_t;

   // Terminal count (N-1) of the prescaler for a given clock select.
   function automatic int unsigned psc_limit(input cs_e sel);
      case (sel)
         CS_DIV8:    return 32'd7;
         CS_DIV64:   return 32'd63;
         CS_DIV256:  return 32'd255;
         CS_DIV1024: return 32'd1023;
         default:    return 32'd0;
      endcase
   endfunction

   function automatic logic psc_running(input cs_e sel);
      case (sel)
         CS_DIV1, CS_DIV8, CS_DIV64, CS_DIV256, CS_DIV1024: return 1'b1;
         default:                                           return 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/io_timer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : io_timer_prescaler
//  Description : Clock-select prescaler; one-cycle tick every N clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_timer_prescaler
   import io_timer_pkg::*;
#(
   parameter int PSC_WIDTH = 10
)(
   input  logic clk,
   input  logic reset,
   input  cs_e  cs_sel,
   input  logic clear,
   output logic tick
);

   logic [PSC_WIDTH-1:0] r_psc;
   logic [PSC_WIDTH-1:0] w_limit;
   logic                 w_run;

   always_comb begin
      w_run   = psc_running(cs_sel);
      w_limit = PSC_WIDTH'(psc_limit(cs_sel));
   end

   assign tick = w_run & (r_psc == w_limit);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_psc <= '0;
      end else if (clear || !w_run || tick) begin
         r_psc <= '0;
      end else begin
         r_psc <= r_psc + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/io_timer.sv
`default_nettype none
// ============================================================================
//  Module      : io_timer
//  Description : Memory-mapped 8-bit timer/counter with compare and irq.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_timer
   import io_timer_pkg::*;
#(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 16'h0020,
   parameter int                    PSC_WIDTH  = 10
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cs,
   input  logic                  we,
   input  logic                  oe,
   input  logic [ADDR_WIDTH-1:0] address,
   inout  wire  [DATA_WIDTH-1:0] data,
   output logic                  irq
);

   tccr_t                 r_tccr;
   logic [DATA_WIDTH-1:0] r_tcnt;
   logic [DATA_WIDTH-1:0] r_ocr;
   logic                  r_tov;
   logic                  r_ocf;
   logic                  r_irq;

   logic                  w_hit;
   logic [1:0]            w_off;
   logic                  w_wr;
   logic                  w_rd;
   logic                  w_wr_tccr;
   logic                  w_wr_tcnt;
   logic                  w_wr_ocr;
   logic                  w_wr_tifr;
   logic                  w_tick;
   logic                  w_cnt_evt;
   logic                  w_cmp;
   logic                  w_ovf;
   logic [DATA_WIDTH-1:0] w_rd_data;

   assign w_hit     = cs & (address[ADDR_WIDTH-1:2] == BASE_ADDR[ADDR_WIDTH-1:2]);
   assign w_off     = address[1:0];
   assign w_wr      = w_hit & we;
   assign w_rd      = w_hit & oe & ~we;
   assign w_wr_tccr = w_wr & (w_off == c_reg_tccr);
   assign w_wr_tcnt = w_wr & (w_off == c_reg_tcnt);
   assign w_wr_ocr  = w_wr & (w_off == c_reg_ocr);
   assign w_wr_tifr = w_wr & (w_off == c_reg_tifr);

   io_timer_prescaler #(
      .PSC_WIDTH (PSC_WIDTH)
   ) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .cs_sel (r_tccr.cs),
      .clear  (w_wr_tccr),
      .tick   (w_tick)
   );

   // A CPU write to TCNT swallows the tick entirely, flags included.
   assign w_cnt_evt = w_tick & ~w_wr_tcnt;
   assign w_cmp     = w_cnt_evt & (r_tcnt == r_ocr);
   assign w_ovf     = w_cnt_evt & (r_tcnt == '1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tccr <= '0;
         r_tcnt <= '0;
         r_ocr  <= '0;
         r_tov  <= 1'b0;
         r_ocf  <= 1'b0;
         r_irq  <= 1'b0;
      end else begin
         if (w_wr_tccr) r_tccr <= tccr_t'(data[5:0]);
         if (w_wr_ocr)  r_ocr  <= data;

         if (w_wr_tcnt) begin
            r_tcnt <= data;
         end else if (w_cnt_evt) begin
            r_tcnt <= (w_cmp && r_tccr.ctc) ? '0 : r_tcnt + 1'b1;
         end

         // Hardware set dominates a write-1-to-clear in the same cycle.
         r_tov <= w_ovf | (r_tov & ~(w_wr_tifr & data[c_tifr_tov]));
         r_ocf <= w_cmp | (r_ocf & ~(w_wr_tifr & data[c_tifr_ocf]));
         r_irq <= (r_tov & r_tccr.toie) | (r_ocf & r_tccr.ocie);
      end
   end

   always_comb begin
      w_rd_data = '0;
      case (w_off)
         c_reg_tccr: w_rd_data[5:0] = r_tccr;
         c_reg_tcnt: w_rd_data      = r_tcnt;
         c_reg_ocr:  w_rd_data      = r_ocr;
         c_reg_tifr: begin
            w_rd_data[c_tifr_ocf] = r_ocf;
            w_rd_data[c_tifr_tov] = r_tov;
         end
         default:    w_rd_data      = '0;
      endcase
   end

   assign data = w_rd ? w_rd_data : 'z;
   assign irq  = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_io_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_timer
//  Description : Directed scoreboard bench for io_timer (bus, counting, irq).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_timer;

   localparam logic [15:0] c_base = 16'h0020;
   localparam logic [1:0]  c_tccr = 2'd0;
   localparam logic [1:0]  c_tcnt = 2'd1;
   localparam logic [1:0]  c_ocr  = 2'd2;
   localparam logic [1:0]  c_tifr = 2'd3;

   logic        clk     = 1'b0;
   logic        reset   = 1'b0;
   logic        cs      = 1'b0;
   logic        we      = 1'b0;
   logic        oe      = 1'b0;
   logic        drv     = 1'b0;
   logic [15:0] address = 16'h0000;
   logic [7:0]  wdata   = 8'h00;
   logic        irq;
   wire  [7:0]  data;

   // Undriven bus floats high so a stray DUT driver shows up as a value change.
   assign data = drv ? wdata : 8'bz;
   pullup (data);

   io_timer #(
      .DATA_WIDTH (8),
      .ADDR_WIDTH (16),
      .BASE_ADDR  (c_base),
      .PSC_WIDTH  (10)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .cs      (cs),
      .we      (we),
      .oe      (oe),
      .address (address),
      .data    (data),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [7:0] exp_data;
      bit         chk_irq;
      logic       exp_irq;
   } exp_t;

   exp_t sb[$];
   bit   chk_req  = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always @(negedge clk) begin
      exp_t e;
      if (chk_req) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty: check requested with no expectation queued");
         end else begin
            e = sb.pop_front();
            checks++;
            if (data !== e.exp_data) begin
               failures++;
               $display("FAIL %s: data=%h expected=%h", e.name, data, e.exp_data);
            end
            if (e.chk_irq) begin
               checks++;
               if (irq !== e.exp_irq) begin
                  failures++;
                  $display("FAIL %s_irq: irq=%b expected=%b", e.name, irq, e.exp_irq);
               end
            end
         end
      end
   end

   task automatic drive(input logic c, input logic w, input logic o, input logic d,
                        input logic [15:0] a, input logic [7:0] v);
      @(posedge clk);
      #1;
      cs = c; we = w; oe = o; drv = d; address = a; wdata = v;
      chk_req = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
   endtask

   task automatic wr(input logic [1:0] off, input logic [7:0] v);
      drive(1'b1, 1'b1, 1'b0, 1'b1, c_base + 16'(off), v);
   endtask

   task automatic expect_cycle(input logic c, input logic w, input logic o,
                               input logic [15:0] a, input logic [7:0] exp_d,
                               input bit ci, input logic ei, input string nm);
      exp_t e;
      drive(c, w, o, 1'b0, a, 8'h00);
      e.name = nm; e.exp_data = exp_d; e.chk_irq = ci; e.exp_irq = ei;
      sb.push_back(e);
      chk_req = 1'b1;
   endtask

   task automatic rd(input logic [1:0] off, input logic [7:0] exp_d, input string nm);
      expect_cycle(1'b1, 1'b0, 1'b1, c_base + 16'(off), exp_d, 1'b0, 1'b0, nm);
   endtask

   task automatic rdi(input logic [1:0] off, input logic [7:0] exp_d, input logic ei,
                      input string nm);
      expect_cycle(1'b1, 1'b0, 1'b1, c_base + 16'(off), exp_d, 1'b1, ei, nm);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      // Reset while running with a pending interrupt.
      wr(c_tcnt, 8'hFE);
      wr(c_tccr, 8'h11);
      idle(3);
      rdi(c_tcnt, 8'h01, 1'b1, "pre_reset_count");
      idle(1);
      reset = 1'b0;
      idle(1);
      rdi(c_tccr, 8'h00, 1'b0, "in_reset_tccr");
      idle(1);
      reset = 1'b1;
      rdi(c_tccr, 8'h00, 1'b0, "reset_tccr");
      rd (c_tcnt, 8'h00, "reset_tcnt");
      rd (c_ocr,  8'h00, "reset_ocr");
      rd (c_tifr, 8'h00, "reset_tifr");
      expect_cycle(1'b0, 1'b0, 1'b0, 16'h0000, 8'hFF, 1'b1, 1'b0, "reset_bus_float");
      idle(2);
      rd (c_tcnt, 8'h00, "reset_stopped");

      // Overflow at /1 with TOIE.
      wr(c_tcnt, 8'hFD);
      wr(c_tccr, 8'h11);
      rd (c_tcnt, 8'hFD, "div1_fd");
      rd (c_tcnt, 8'hFE, "div1_fe");
      rd (c_tcnt, 8'hFF, "div1_ff");
      rdi(c_tcnt, 8'h00, 1'b0, "div1_wrap");
      rdi(c_tifr, 8'h03, 1'b1, "tov_set");
      wr(c_tifr, 8'h01);
      rdi(c_tifr, 8'h02, 1'b1, "tov_clr_lag");
      rdi(c_tifr, 8'h02, 1'b0, "tov_clr");

      // CTC at /8 with OCR=5.
      wr(c_tccr, 8'h00);
      wr(c_tcnt, 8'h00);
      wr(c_ocr,  8'h05);
      wr(c_tifr, 8'hFF);
      wr(c_tccr, 8'h2A);
      idle(7);
      rd (c_tcnt, 8'h00, "div8_before_tick");
      rd (c_tcnt, 8'h01, "div8_first_tick");
      idle(37);
      rd (c_tcnt, 8'h05, "ctc_at_ocr");
      rdi(c_tifr, 8'h00, 1'b0, "ctc_no_flag_yet");
      rdi(c_tcnt, 8'h00, 1'b0, "ctc_clear");
      rdi(c_tifr, 8'h02, 1'b1, "ocf_set");

      // Same-cycle collisions at /1.
      wr(c_tccr, 8'h00);
      wr(c_tifr, 8'hFF);
      wr(c_tcnt, 8'h20);
      wr(c_ocr,  8'h22);
      wr(c_tccr, 8'h01);
      idle(2);
      wr(c_tcnt, 8'h40);
      rd (c_tcnt, 8'h40, "tcnt_write_wins");
      rd (c_tifr, 8'h00, "tick_flags_dropped");
      wr(c_ocr,  8'h42);
      rd (c_tifr, 8'h00, "ocr_old_compare");
      wr(c_ocr,  8'h46);
      rd (c_tcnt, 8'h45, "count_resumes");
      wr(c_tifr, 8'h02);
      rd (c_tifr, 8'h02, "set_beats_clear");
      wr(c_tifr, 8'h02);
      rd (c_tifr, 8'h00, "ocf_cleared");

      // Bus isolation and reserved bits.
      wr(c_tccr, 8'hFF);
      rdi(c_tccr, 8'h3F, 1'b0, "tccr_reserved");
      wr(c_tifr, 8'hFC);
      rd (c_tifr, 8'h00, "tifr_reserved");
      expect_cycle(1'b1, 1'b0, 1'b1, c_base + 16'd4, 8'hFF, 1'b0, 1'b0, "miss_base_plus4");
      expect_cycle(1'b1, 1'b0, 1'b1, c_base - 16'd1, 8'hFF, 1'b0, 1'b0, "miss_base_minus1");
      expect_cycle(1'b1, 1'b0, 1'b1, 16'h0120,       8'hFF, 1'b0, 1'b0, "miss_high_alias");
      expect_cycle(1'b0, 1'b0, 1'b1, c_base,         8'hFF, 1'b0, 1'b0, "cs_low_float");
      expect_cycle(1'b1, 1'b1, 1'b1, c_base + 16'd2, 8'hFF, 1'b0, 1'b0, "we_oe_no_drive");
      rd (c_ocr,  8'hFF, "we_oe_is_write");
      rd (c_tcnt, 8'h4B, "cs7_stopped");

      idle(2);
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover: pending=%0d expected=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
